// File: rtl/zeroriscy_instr_arbiter.sv
// rtl/zeroriscy_instr_arbiter.sv - two-master round-robin arbiter for the instruction memory port
module zeroriscy_instr_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              instr_req_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  input  logic              instr_gnt_i,
  input  logic              instr_rvalid_i,
  input  logic [DATA_W-1:0] instr_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // Arbitration state
  logic          sel_q;
  logic          locked_q;
  logic          prio_q;

  // In-order ID FIFO: one master-ID bit per outstanding transaction
  logic [DEPTH-1:0] id_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic sel;
  logic req_sel;
  logic not_full;
  logic handshake;
  logic pop;
  logic head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    ptr_next = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pick the master: a stalled request keeps its lock, otherwise single requester or round-robin pointer
  always_comb begin
    sel = prio_q;
    if (locked_q) begin
      sel = sel_q;
    end else if (m0_req_i && !m1_req_i) begin
      sel = 1'b0;
    end else if (m1_req_i && !m0_req_i) begin
      sel = 1'b1;
    end
  end

  assign req_sel      = sel ? m1_req_i : m0_req_i;
  assign not_full     = (count_q < CW'(DEPTH));
  assign instr_req_o  = req_sel & not_full;
  assign instr_addr_o = sel ? m1_addr_i : m0_addr_i;
  assign handshake    = instr_req_o & instr_gnt_i;
  assign m0_gnt_o     = handshake & ~sel;
  assign m1_gnt_o     = handshake & sel;

  // Responses return in order; a response with nothing outstanding is flagged and dropped
  assign head        = id_q[rd_ptr_q];
  assign pop         = instr_rvalid_i & (count_q != '0);
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign rdata_o     = instr_rdata_i;
  assign err_o       = instr_rvalid_i & (count_q == '0);
  assign busy_o      = (count_q != '0) | instr_req_o;

  // Round-robin pointer and stall lock update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= 1'b0;
      locked_q <= 1'b0;
      prio_q   <= 1'b0;
    end else if (handshake) begin
      prio_q   <= ~sel;
      locked_q <= 1'b0;
    end else if (instr_req_o) begin
      locked_q <= 1'b1;
      sel_q    <= sel;
    end else if (locked_q && !req_sel) begin
      locked_q <= 1'b0;
    end
  end

  // ID FIFO push on handshake, pop on response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (handshake) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (handshake && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !handshake) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_instr_arbiter.sv
// tb/tb_zeroriscy_instr_arbiter.sv - directed self-checking bench for zeroriscy_instr_arbiter
module tb_zeroriscy_instr_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] rdata;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        gnt, rvalid;
  logic [31:0] instr_rdata;
  logic        busy, err;

  int checks = 0;
  int errors = 0;

  zeroriscy_instr_arbiter #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .rdata_o(rdata),
    .instr_req_o(instr_req), .instr_addr_o(instr_addr), .instr_gnt_i(gnt),
    .instr_rvalid_i(rvalid), .instr_rdata_i(instr_rdata),
    .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0;
    gnt = 0; rvalid = 0; instr_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    #12;
    chk("rst_req", instr_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_gnts", {m0_gnt, m1_gnt}, 0);
    chk("rst_rvalids", {m0_rvalid, m1_rvalid}, 0);
    @(negedge clk);
    rst = 0;

    // single master stream
    tick(); m0_req = 1; m0_addr = 32'h100; gnt = 1; #1;
    chk("s_req0", instr_req, 1);
    chk("s_addr0", instr_addr, 32'h100);
    chk("s_gnt0", {m0_gnt, m1_gnt}, 2'b10);
    chk("s_busy0", busy, 1);
    tick(); m0_addr = 32'h104; rvalid = 1; instr_rdata = 32'hD0; #1;
    chk("s_gnt1", {m0_gnt, m1_gnt}, 2'b10);
    chk("s_rv1", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("s_data1", rdata, 32'hD0);
    tick(); m0_addr = 32'h108; instr_rdata = 32'hD1; #1;
    chk("s_gnt2", {m0_gnt, m1_gnt}, 2'b10);
    chk("s_addr2", instr_addr, 32'h108);
    chk("s_rv2", {m0_rvalid, m1_rvalid}, 2'b10);
    tick(); m0_req = 0; instr_rdata = 32'hD2; #1;
    chk("s_req3", instr_req, 0);
    chk("s_rv3", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("s_data3", rdata, 32'hD2);
    chk("s_busy3", busy, 1);
    tick(); rvalid = 0; #1;
    chk("s_busy4", busy, 0);
    chk("s_rv4", {m0_rvalid, m1_rvalid}, 2'b00);

    // round-robin from reset
    do_reset();
    tick(); m0_req = 1; m1_req = 1; m0_addr = 32'h200; m1_addr = 32'h300; gnt = 1; #1;
    chk("rr_g0", {m0_gnt, m1_gnt}, 2'b10);
    chk("rr_a0", instr_addr, 32'h200);
    tick(); rvalid = 1; instr_rdata = 32'hA0; #1;
    chk("rr_g1", {m0_gnt, m1_gnt}, 2'b01);
    chk("rr_a1", instr_addr, 32'h300);
    chk("rr_rv1", {m0_rvalid, m1_rvalid}, 2'b10);
    tick(); instr_rdata = 32'hA1; #1;
    chk("rr_g2", {m0_gnt, m1_gnt}, 2'b10);
    chk("rr_rv2", {m0_rvalid, m1_rvalid}, 2'b01);
    tick(); m0_req = 0; m1_req = 0; #1;
    chk("rr_rv3", {m0_rvalid, m1_rvalid}, 2'b10);
    tick(); rvalid = 0; #1;
    chk("rr_busy", busy, 0);

    // lock under stall (prio_q is 0 after reset, so only the lock keeps m1 selected)
    do_reset();
    tick(); m1_req = 1; m1_addr = 32'h400; gnt = 0; #1;
    chk("lk_req0", instr_req, 1);
    chk("lk_addr0", instr_addr, 32'h400);
    chk("lk_g0", {m0_gnt, m1_gnt}, 2'b00);
    tick(); m0_req = 1; m0_addr = 32'h500; #1;
    chk("lk_addr1", instr_addr, 32'h400);
    chk("lk_g1", {m0_gnt, m1_gnt}, 2'b00);
    tick(); m1_addr = 32'h440; #1;
    chk("lk_addr2", instr_addr, 32'h440);
    chk("lk_g2", {m0_gnt, m1_gnt}, 2'b00);
    tick(); gnt = 1; #1;
    chk("lk_g3", {m0_gnt, m1_gnt}, 2'b01);
    chk("lk_addr3", instr_addr, 32'h440);
    tick(); m1_req = 0; rvalid = 1; instr_rdata = 32'hB0; #1;
    chk("lk_g4", {m0_gnt, m1_gnt}, 2'b10);
    chk("lk_addr4", instr_addr, 32'h500);
    chk("lk_rv4", {m0_rvalid, m1_rvalid}, 2'b01);
    tick(); m0_req = 0; instr_rdata = 32'hB1; #1;
    chk("lk_rv5", {m0_rvalid, m1_rvalid}, 2'b10);
    tick(); rvalid = 0; #1;
    chk("lk_busy", busy, 0);

    // FIFO full
    tick(); m0_req = 1; m0_addr = 32'h600; gnt = 1; #1;
    chk("ff_g0", {m0_gnt, m1_gnt}, 2'b10);
    tick(); m0_addr = 32'h604; #1;
    chk("ff_g1", {m0_gnt, m1_gnt}, 2'b10);
    tick(); m0_addr = 32'h608; #1;
    chk("ff_req2", instr_req, 0);
    chk("ff_g2", {m0_gnt, m1_gnt}, 2'b00);
    chk("ff_busy2", busy, 1);
    tick(); rvalid = 1; instr_rdata = 32'hC0; #1;
    chk("ff_req3", instr_req, 0);
    chk("ff_rv3", {m0_rvalid, m1_rvalid}, 2'b10);
    tick(); rvalid = 0; #1;
    chk("ff_req4", instr_req, 1);
    chk("ff_g4", {m0_gnt, m1_gnt}, 2'b10);
    chk("ff_addr4", instr_addr, 32'h608);
    tick(); m0_req = 0; rvalid = 1; #1;
    chk("ff_rv5", {m0_rvalid, m1_rvalid}, 2'b10);
    tick(); #1;
    chk("ff_rv6", {m0_rvalid, m1_rvalid}, 2'b10);
    tick(); rvalid = 0; #1;
    chk("ff_busy7", busy, 0);

    // spurious rvalid
    tick(); rvalid = 1; #1;
    chk("sp_err", err, 1);
    chk("sp_rv", {m0_rvalid, m1_rvalid}, 2'b00);
    chk("sp_busy", busy, 0);
    tick(); rvalid = 0; #1;
    chk("sp_err_off", err, 0);
    chk("sp_busy2", busy, 0);

    // reset mid-flight
    tick(); m0_req = 1; m0_addr = 32'h700; gnt = 1; #1;
    chk("rm_g0", {m0_gnt, m1_gnt}, 2'b10);
    tick(); m0_addr = 32'h704; #1;
    chk("rm_g1", {m0_gnt, m1_gnt}, 2'b10);
    tick(); m0_req = 0; #1;
    chk("rm_busy_pre", busy, 1);
    clear_inputs();
    rst = 1;
    #1;
    chk("rm_busy_rst", busy, 0);
    chk("rm_req_rst", instr_req, 0);
    @(negedge clk);
    rst = 0;
    tick(); rvalid = 1; #1;
    chk("rm_err", err, 1);
    chk("rm_rv", {m0_rvalid, m1_rvalid}, 2'b00);
    tick(); rvalid = 0; m0_req = 1; m1_req = 1; m0_addr = 32'h800; m1_addr = 32'h900; gnt = 1; #1;
    chk("rm_g2", {m0_gnt, m1_gnt}, 2'b10);
    chk("rm_err_off", err, 0);
    tick(); #1;
    chk("rm_g3", {m0_gnt, m1_gnt}, 2'b01);
    chk("rm_addr3", instr_addr, 32'h900);
    tick(); m0_req = 0; m1_req = 0; rvalid = 1; #1;
    chk("rm_rv4", {m0_rvalid, m1_rvalid}, 2'b10);
    tick(); #1;
    chk("rm_rv5", {m0_rvalid, m1_rvalid}, 2'b01);
    tick(); rvalid = 0; #1;
    chk("rm_busy_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
